alu_addsub16: RTL and testbench
===============================

Name: alu_addsub16

Overview:
- 16-bit add/subtract ALU with carry and borrow support, used in the single-cycle RISC datapath.
- Four operations: ADD, ADC (add with carry), SUB, SBB (subtract with borrow).
- Produces a 16-bit result, a carry out of bit 15, and a carry out of bit 14.
- Result and flags are registered: one clock, asynchronous active-low reset.

Parameters:
- WIDTH, 16, operand/result width. Cout_1 is always the carry out of bit WIDTH-2.

Ports:
- clk  in  1  system clock; all outputs update on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low; clears all outputs.
- A  in  16  operand A (minuend for SUB/SBB).
- B  in  16  operand B (subtrahend for SUB/SBB).
- SBB  in  1  select subtract-with-borrow: Y = A - B - C.
- SUB  in  1  select subtract: Y = A - B.
- C  in  1  carry/borrow input flag, used only by ADC and SBB.
- ADC  in  1  select add-with-carry: Y = A + B + C.
- Y  out  16  registered result.
- Cout  out  1  registered carry out of bit 15. For SUB/SBB, 1 means no borrow.
- Cout_1  out  1  registered carry out of bit 14, i.e. carry into bit 15. Signed overflow V = Cout XOR Cout_1.

Behaviour:
- Core is a single 16-bit ripple-carry adder built from per-bit full-adder cells. It computes S = A + Bx + cin (17-bit).
  - Cout = carry out of bit 15.
  - Cout_1 = carry out of bit 14.
- Operand and carry-in selection, with fixed priority SBB > SUB > ADC > ADD:
  - SBB=1: Bx = ~B, cin = ~C.
  - SUB=1 (SBB=0): Bx = ~B, cin = 1.
  - ADC=1 (SBB=SUB=0): Bx = B, cin = C.
  - All selects 0: plain ADD, Bx = B, cin = 0.
- Multiple selects asserted at once: the highest-priority select wins. No error is flagged.
- Arithmetic is modulo 2^16. There is no saturation; wrap-around is reported only via Cout/Cout_1.
- Timing:
  - Inputs are sampled at the rising edge of clk.
  - Y, Cout and Cout_1 reflect those inputs after that edge, so latency is 1 cycle.
  - A new operation can be issued every cycle; there is no handshake.
- Reset:
  - While rst_n=0: Y=16'h0000, Cout=0, Cout_1=0, held regardless of clk.
  - Reset assertion mid-operation clears the outputs immediately (asynchronously).
  - The first rising edge with rst_n=1 loads the result of the current inputs.
- C is ignored for ADD and SUB.

Test Plan:
- Reset and zero:
  - rst_n=0 → Y=0000, Cout=0, Cout_1=0.
  - Release reset, all inputs 0 (ADD 0+0), clock → Y=0000, Cout=0, Cout_1=0.
- SBB, A=4567, B=1234:
  - C=0 → Y=3333, Cout=1, Cout_1=1.
  - C=1 → Y=3332, Cout=1, Cout_1=1.
  - Each result appears one edge after the inputs are applied.
- SUB, A=4567, B=1234:
  - C=0 → Y=3333, Cout=1, Cout_1=1.
  - Repeat with C=1 → result unchanged (C ignored).
- ADC, A=4567, B=1234:
  - C=0 → Y=579B, Cout=0, Cout_1=0.
  - C=1 → Y=579C, Cout=0, Cout_1=0.
- Boundaries:
  - ADD FFFF+0001 → Y=0000, Cout=1, Cout_1=1.
  - ADD 7FFF+0001 → Y=8000, Cout=0, Cout_1=1 (overflow).
  - SUB 0000-0001 → Y=FFFF, Cout=0 (borrow).
- Priority and async reset:
  - SBB=SUB=ADC=1, C=1, A=4567, B=1234 → Y=3332 (SBB wins).
  - Assert rst_n=0 between clock edges → outputs clear to 0 immediately.

Source files
------------

// File: rtl/alu_addsub16_if.sv
// Operand/select/result bundle for the registered 16-bit add/subtract ALU.
// Latency: pure wiring; the ALU registers the result one clock after sampling.
// Backpressure: none; the master may present a new operation every cycle.
interface alu_addsub16_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             SBB;
  logic             SUB;
  logic             C;
  logic             ADC;
  logic [WIDTH-1:0] Y;
  logic             Cout;
  logic             Cout_1;

  // Operation source (datapath control / testbench)
  modport master (
    output A, B, SBB, SUB, C, ADC,
    input  Y, Cout, Cout_1
  );

  // The ALU itself
  modport slave (
    input  A, B, SBB, SUB, C, ADC,
    output Y, Cout, Cout_1
  );
endinterface

// File: rtl/alu_addsub16.sv
// 16-bit ripple-carry ADD/ADC/SUB/SBB with carry-out of the top two bits.
// Latency: 1 clock (result, Cout and Cout_1 registered); async active-low clear.
// Backpressure: none; one operation accepted every cycle, no handshake.

// One full-adder cell of the ripple chain.
module alu_addsub16_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic co_o
);
  assign s_o  = a_i ^ b_i ^ c_i;
  assign co_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module alu_addsub16 #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_addsub16_if.slave      bus
);

  // Adder operands after select decoding
  logic [WIDTH-1:0] bx;
  logic             cin;

  // Ripple carry chain: carry[i] is the carry into bit i, carry[WIDTH] out of the MSB
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;

  // Registered outputs
  logic [WIDTH-1:0] y_q, y_d;
  logic             cout_q, cout_d;
  logic             cout1_q, cout1_d;

  // Operand/carry-in selection, fixed priority SBB > SUB > ADC > ADD.
  // Subtraction is A + ~B + 1; with borrow the +1 becomes ~C, so Cout=1 means no borrow.
  always_comb begin
    bx  = bus.B;
    cin = 1'b0;
    if (bus.SBB) begin
      bx  = ~bus.B;
      cin = ~bus.C;
    end else if (bus.SUB) begin
      bx  = ~bus.B;
      cin = 1'b1;
    end else if (bus.ADC) begin
      bx  = bus.B;
      cin = bus.C;
    end
  end

  assign carry[0] = cin;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_fa
      alu_addsub16_fa u_fa (
        .a_i  (bus.A[gi]),
        .b_i  (bx[gi]),
        .c_i  (carry[gi]),
        .s_o  (sum[gi]),
        .co_o (carry[gi+1])
      );
    end
  endgenerate

  // Next-state of the output registers: sum plus the two top carries (V = Cout ^ Cout_1)
  always_comb begin
    y_d     = sum;
    cout_d  = carry[WIDTH];
    cout1_d = carry[WIDTH-1];
  end

  // Output registers, cleared immediately while rst_n is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q     <= '0;
      cout_q  <= 1'b0;
      cout1_q <= 1'b0;
    end else begin
      y_q     <= y_d;
      cout_q  <= cout_d;
      cout1_q <= cout1_d;
    end
  end

  assign bus.Y      = y_q;
  assign bus.Cout   = cout_q;
  assign bus.Cout_1 = cout1_q;

endmodule

// File: tb/tb_alu_addsub16.sv
// Directed-vector bench for alu_addsub16 with hand-computed expected values.
// Latency: checks taken 1 time unit after the capturing rising edge.
// Backpressure: none; inputs driven on the falling edge.
module tb_alu_addsub16;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  alu_addsub16_if #(.WIDTH(16)) bus ();

  alu_addsub16 #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [15:0] y,
                            input logic co, input logic co1);
    check({tag, ".Y"},      {16'h0, bus.Y},      {16'h0, y});
    check({tag, ".Cout"},   {31'h0, bus.Cout},   {31'h0, co});
    check({tag, ".Cout_1"}, {31'h0, bus.Cout_1}, {31'h0, co1});
  endtask

  // Drive one operation on the falling edge: {SBB,SUB,ADC}, C, A, B
  task automatic drive(input logic [2:0] sel, input logic c,
                       input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    bus.SBB = sel[2];
    bus.SUB = sel[1];
    bus.ADC = sel[0];
    bus.C   = c;
    bus.A   = a;
    bus.B   = b;
  endtask

  task automatic op(input string tag, input logic [2:0] sel, input logic c,
                    input logic [15:0] a, input logic [15:0] b,
                    input logic [15:0] y, input logic co, input logic co1);
    drive(sel, c, a, b);
    @(posedge clk);
    #1;
    expect_out(tag, y, co, co1);
  endtask

  localparam logic [2:0] S_ADD = 3'b000;
  localparam logic [2:0] S_ADC = 3'b001;
  localparam logic [2:0] S_SUB = 3'b010;
  localparam logic [2:0] S_SBB = 3'b100;

  initial begin
    rst_n   = 1'b0;
    bus.A   = '0;
    bus.B   = '0;
    bus.SBB = 1'b0;
    bus.SUB = 1'b0;
    bus.ADC = 1'b0;
    bus.C   = 1'b0;

    #3;
    expect_out("reset", 16'h0000, 1'b0, 1'b0);

    // Reset holds outputs even across a clock edge with nonzero inputs
    drive(S_ADD, 1'b0, 16'h4567, 16'h1234);
    @(posedge clk);
    #1;
    expect_out("reset_hold", 16'h0000, 1'b0, 1'b0);

    // Release reset with all inputs zero: ADD 0+0
    @(negedge clk);
    rst_n   = 1'b1;
    bus.A   = '0;
    bus.B   = '0;
    @(posedge clk);
    #1;
    expect_out("add_zero", 16'h0000, 1'b0, 1'b0);

    // SBB with one-cycle latency check: output unchanged before the edge
    drive(S_SBB, 1'b0, 16'h4567, 16'h1234);
    #1;
    check("latency_pre_edge", {16'h0, bus.Y}, 32'h0000_0000);
    @(posedge clk);
    #1;
    expect_out("sbb_c0", 16'h3333, 1'b1, 1'b1);

    op("sbb_c1", S_SBB, 1'b1, 16'h4567, 16'h1234, 16'h3332, 1'b1, 1'b1);
    op("sub_c0", S_SUB, 1'b0, 16'h4567, 16'h1234, 16'h3333, 1'b1, 1'b1);
    op("sub_c1", S_SUB, 1'b1, 16'h4567, 16'h1234, 16'h3333, 1'b1, 1'b1);
    op("adc_c0", S_ADC, 1'b0, 16'h4567, 16'h1234, 16'h579B, 1'b0, 1'b0);
    op("adc_c1", S_ADC, 1'b1, 16'h4567, 16'h1234, 16'h579C, 1'b0, 1'b0);
    op("add_c_ignored", S_ADD, 1'b1, 16'h4567, 16'h1234, 16'h579B, 1'b0, 1'b0);

    // Boundaries
    op("add_ffff_1", S_ADD, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1);
    op("add_7fff_1", S_ADD, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);
    op("sub_0_1",    S_SUB, 1'b0, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0);
    op("sub_8000_1", S_SUB, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b0);

    // Priority: all selects high, SBB wins
    op("prio_all", 3'b111, 1'b1, 16'h4567, 16'h1234, 16'h3332, 1'b1, 1'b1);
    // SUB beats ADC
    op("prio_sub_adc", 3'b011, 1'b1, 16'h4567, 16'h1234, 16'h3333, 1'b1, 1'b1);

    // Asynchronous reset between edges clears outputs immediately
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("async_reset", 16'h0000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    expect_out("async_reset_hold", 16'h0000, 1'b0, 1'b0);

    // First edge after release loads the current inputs (SUB+ADC: SUB wins)
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    expect_out("post_release", 16'h3333, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
